imem_arbiter: RTL

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one combinational instruction ROM between the fetch
// unit and the debug/loader port. Fetch normally wins; a debug requester
// that has been blocked STARVE_MAX cycles in a row wins the next cycle.
// Responses are registered and returned exactly one cycle after the grant.
module imem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              if_flush,
  // debug / loader port
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_err,
  // instruction ROM
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_pc,
  input  logic [31:0]       rom_instr
);

  typedef enum logic [0:0] {
    IF_PRI  = 1'b0,
    DBG_PRI = 1'b1
  } pri_state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] CNT_MAX    = 4'd15;

  pri_state_t        state_r;
  pri_state_t        state_next_s;
  logic [3:0]        wait_cnt_r;
  logic [3:0]        wait_cnt_next_s;

  logic              if_gnt_s;
  logic              dbg_gnt_s;
  logic              any_gnt_s;
  logic              aligned_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic              rom_ce_s;
  logic [ADDR_W-1:0] rom_pc_s;
  logic [31:0]       rsp_data_s;
  logic              rsp_err_s;

  logic              if_rvalid_r;
  logic [31:0]       if_rdata_r;
  logic              if_err_r;
  logic              dbg_rvalid_r;
  logic [31:0]       dbg_rdata_r;
  logic              dbg_err_r;

  // Grant decision: the prioritised requester wins, the other gets the idle port.
  always_comb begin
    if_gnt_s  = 1'b0;
    dbg_gnt_s = 1'b0;
    if (!rst) begin
      if_gnt_s  = 1'b0;
      dbg_gnt_s = 1'b0;
    end else begin
      case (state_r)
        IF_PRI: begin
          if_gnt_s  = if_req;
          dbg_gnt_s = dbg_req & ~if_req;
        end
        DBG_PRI: begin
          dbg_gnt_s = dbg_req;
          if_gnt_s  = if_req & ~dbg_req;
        end
        default: begin
          if_gnt_s  = 1'b0;
          dbg_gnt_s = 1'b0;
        end
      endcase
    end
  end

  // Starvation counter and priority next-state.
  always_comb begin
    wait_cnt_next_s = 4'd0;
    state_next_s    = state_r;
    if (dbg_req && !dbg_gnt_s) begin
      wait_cnt_next_s = (wait_cnt_r == CNT_MAX) ? CNT_MAX : (wait_cnt_r + 4'd1);
    end else begin
      wait_cnt_next_s = 4'd0;
    end
    case (state_r)
      IF_PRI: begin
        if (wait_cnt_next_s >= STARVE_LIM) begin
          state_next_s = DBG_PRI;
        end else begin
          state_next_s = IF_PRI;
        end
      end
      DBG_PRI: begin
        if (dbg_gnt_s || !dbg_req) begin
          state_next_s = IF_PRI;
        end else begin
          state_next_s = DBG_PRI;
        end
      end
      default: state_next_s = IF_PRI;
    endcase
  end

  // Priority state and wait counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IF_PRI;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // Winner address mux and ROM access; misaligned accesses never touch the ROM.
  always_comb begin
    win_addr_s = '0;
    if (if_gnt_s) begin
      win_addr_s = if_addr;
    end else if (dbg_gnt_s) begin
      win_addr_s = dbg_addr;
    end else begin
      win_addr_s = '0;
    end
    any_gnt_s  = if_gnt_s | dbg_gnt_s;
    aligned_s  = (win_addr_s[1:0] == 2'b00);
    rom_ce_s   = any_gnt_s & aligned_s;
    rom_pc_s   = rom_ce_s ? win_addr_s : '0;
    rsp_data_s = aligned_s ? rom_instr : 32'd0;
    rsp_err_s  = ~aligned_s;
  end

  // Response registers: one-cycle latency, data held until that port's next response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_rvalid_r  <= 1'b0;
      if_rdata_r   <= 32'd0;
      if_err_r     <= 1'b0;
      dbg_rvalid_r <= 1'b0;
      dbg_rdata_r  <= 32'd0;
      dbg_err_r    <= 1'b0;
    end else begin
      if_rvalid_r  <= if_gnt_s & ~if_flush;
      dbg_rvalid_r <= dbg_gnt_s;
      if (if_gnt_s && !if_flush) begin
        if_rdata_r <= rsp_data_s;
        if_err_r   <= rsp_err_s;
      end else begin
        if_rdata_r <= if_rdata_r;
        if_err_r   <= if_err_r;
      end
      if (dbg_gnt_s) begin
        dbg_rdata_r <= rsp_data_s;
        dbg_err_r   <= rsp_err_s;
      end else begin
        dbg_rdata_r <= dbg_rdata_r;
        dbg_err_r   <= dbg_err_r;
      end
    end
  end

  // A flush in the presentation cycle also kills the fetch response; reset
  // blanks every response output immediately so nothing leaks while held.
  assign if_gnt     = if_gnt_s;
  assign dbg_gnt    = dbg_gnt_s;
  assign rom_ce     = rom_ce_s;
  assign rom_pc     = rom_pc_s;
  assign if_rvalid  = if_rvalid_r & ~if_flush & rst;
  assign if_rdata   = rst ? if_rdata_r : 32'd0;
  assign if_err     = if_err_r & rst;
  assign dbg_rvalid = dbg_rvalid_r & rst;
  assign dbg_rdata  = rst ? dbg_rdata_r : 32'd0;
  assign dbg_err    = dbg_err_r & rst;

endmodule
